// File: rtl/display_scroll_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scroll_controller_if
//  Description : Bundles the load port, command inputs and display outputs of
//                display_scroll_controller.
//                master : drives load_valid/load_char/load_last, start, pause,
//                         abort; observes load_ready, digit0..3, busy,
//                         wrap_pulse.
//                slave  : the controller side of the same signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scroll_controller_if;
    logic       load_valid;
    logic [3:0] load_char;
    logic       load_last;
    logic       load_ready;
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       busy;
    logic       wrap_pulse;

    modport master (
        output load_valid, load_char, load_last, start, pause, abort,
        input  load_ready, digit0, digit1, digit2, digit3, busy, wrap_pulse
    );

    modport slave (
        input  load_valid, load_char, load_last, start, pause, abort,
        output load_ready, digit0, digit1, digit2, digit3, busy, wrap_pulse
    );
endinterface
`default_nettype wire

// File: rtl/display_scroll_controller.sv
`default_nettype none
// ============================================================================
//  Module      : display_scroll_controller
//  Description : Stores a message of up to MSG_DEPTH 4-bit character codes
//                and scrolls it right-to-left across four display digits,
//                one position every SHIFT_PERIOD cycles.
//  Ports       : clock, reset (sync, active-high)
//                bus.load_valid/load_char/load_last/load_ready - message load
//                bus.start/pause/abort                         - scroll control
//                bus.digit3..digit0 (left..right), bus.busy, bus.wrap_pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scroll_controller #(
    parameter int         MSG_DEPTH    = 16,
    parameter int         SHIFT_PERIOD = 2500000,
    parameter logic [3:0] BLANK        = 4'hF
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    display_scroll_controller_if.slave bus
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = $clog2(MSG_DEPTH + 4);
    localparam int TW = $clog2(SHIFT_PERIOD);
    localparam int AW = $clog2(MSG_DEPTH);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_load   = 2'd1;
    localparam logic [1:0] c_s_scroll = 2'd2;
    localparam logic [1:0] c_s_hold   = 2'd3;

    localparam logic [TW-1:0] c_tick_max = TW'(SHIFT_PERIOD - 1);
    localparam logic [LW-1:0] c_ptr_last = LW'(MSG_DEPTH - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [3:0]    r_buf [MSG_DEPTH];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_len;
    logic [PW-1:0] r_pos;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_digit [4];
    logic          r_busy;
    logic          r_wrap;
    logic          r_load_ready;

    logic          w_xfer;
    logic          w_full;
    logic [PW:0]   w_len4;
    logic [PW-1:0] w_pos_inc;
    logic [PW-1:0] w_pos_next;
    logic [TW-1:0] w_tick_next;
    logic          w_step;
    logic          w_show;
    logic [3:0]    w_dig_next [4];
    logic          w_wrap_next;
    logic          w_ready_next;
    logic [AW-1:0] w_wr_idx;

    // load_ready is only ever high in IDLE/LOAD, so no state qualifier needed.
    assign w_xfer   = bus.load_valid && r_load_ready;
    assign w_full   = (r_wr_ptr == c_ptr_last);
    assign w_wr_idx = (r_state == c_s_idle) ? '0 : r_wr_ptr[AW-1:0];
    assign w_len4   = (PW+1)'(r_len) + (PW+1)'(4);
    assign w_pos_inc = (({1'b0, r_pos} + (PW+1)'(1)) == w_len4) ? '0 : r_pos + PW'(1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle: begin
                if (w_xfer) begin
                    w_state_next = bus.load_last ? c_s_idle : c_s_load;
                end else if (bus.start && (r_len != '0)) begin
                    w_state_next = c_s_scroll;
                end
            end
            c_s_load: begin
                if (w_xfer && (bus.load_last || w_full)) begin
                    w_state_next = c_s_idle;
                end
            end
            c_s_scroll: begin
                if (bus.abort) begin
                    w_state_next = c_s_idle;
                end else if (bus.pause) begin
                    w_state_next = c_s_hold;
                end
            end
            c_s_hold: begin
                if (bus.abort) begin
                    w_state_next = c_s_idle;
                end else if (!bus.pause) begin
                    w_state_next = c_s_scroll;
                end
            end
            default: w_state_next = c_s_idle;
        endcase
    end

    // ------------------------------------------------------- output / next
    always_comb begin
        logic [PW:0] idx;
        w_tick_next = r_tick;
        w_pos_next  = r_pos;
        w_step      = 1'b0;
        idx         = '0;
        if ((r_state == c_s_idle) && (w_state_next == c_s_scroll)) begin
            // Starting at pos=len shows the four trailing blanks.
            w_tick_next = '0;
            w_pos_next  = PW'(r_len);
        end else if ((r_state == c_s_scroll) && !bus.abort) begin
            // A step still completes when pause arrives in the same cycle.
            if (r_tick == c_tick_max) begin
                w_tick_next = '0;
                w_step      = 1'b1;
                w_pos_next  = w_pos_inc;
            end else begin
                w_tick_next = r_tick + TW'(1);
            end
        end

        w_show       = (w_state_next == c_s_scroll) || (w_state_next == c_s_hold);
        w_wrap_next  = w_step && (w_pos_next == PW'(r_len));
        w_ready_next = ((w_state_next == c_s_idle) || (w_state_next == c_s_load)) &&
                       !(w_xfer && (r_state == c_s_load) && w_full);

        // Window onto the virtual stream: message followed by four blanks,
        // indexed modulo len+4. Slot 0 is the leftmost digit.
        for (int k = 0; k < 4; k++) begin
            idx = {1'b0, w_pos_next} + (PW+1)'(k);
            if (idx >= w_len4) begin
                idx = idx - w_len4;
            end
            if (w_show && (idx < (PW+1)'(r_len))) begin
                w_dig_next[k] = r_buf[idx[AW-1:0]];
            end else begin
                w_dig_next[k] = BLANK;
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_len        <= '0;
            r_pos        <= '0;
            r_tick       <= '0;
            r_busy       <= 1'b0;
            r_wrap       <= 1'b0;
            r_load_ready <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                r_digit[k] <= BLANK;
            end
        end else begin
            if (w_xfer) begin
                if (r_state == c_s_idle) begin
                    // First character discards any previous message.
                    r_wr_ptr <= LW'(1);
                    r_len    <= bus.load_last ? LW'(1) : '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + LW'(1);
                    if (bus.load_last || w_full) begin
                        r_len <= r_wr_ptr + LW'(1);
                    end
                end
            end
            r_pos        <= w_pos_next;
            r_tick       <= w_tick_next;
            r_busy       <= w_show;
            r_wrap       <= w_wrap_next;
            r_load_ready <= w_ready_next;
            for (int k = 0; k < 4; k++) begin
                r_digit[k] <= w_dig_next[k];
            end
        end
    end

    // Message storage needs no reset; len gates every read.
    always_ff @(posedge clock) begin
        if (w_xfer) begin
            r_buf[w_wr_idx] <= bus.load_char;
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.busy       = r_busy;
    assign bus.wrap_pulse = r_wrap;
    assign bus.digit3     = r_digit[0];
    assign bus.digit2     = r_digit[1];
    assign bus.digit1     = r_digit[2];
    assign bus.digit0     = r_digit[3];

endmodule
`default_nettype wire

// File: tb/tb_display_scroll_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scroll_controller
//  Description : Self-checking bench for display_scroll_controller
//                (MSG_DEPTH=4, SHIFT_PERIOD=4). Stimulus pushes the expected
//                display changes with their cycle numbers into a queue; a
//                monitor pops and compares on every observed change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scroll_controller;

    typedef struct {
        logic [15:0] dig;
        logic        wrap;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic [15:0] prev;
    exp_t q [$];

    display_scroll_controller_if bus ();

    display_scroll_controller #(
        .MSG_DEPTH    (4),
        .SHIFT_PERIOD (4),
        .BLANK        (4'hF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] disp();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic w, input int c);
        exp_t e;
        e.dig  = d;
        e.wrap = w;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic send(input logic [3:0] ch, input logic last);
        int n;
        bus.load_valid = 1'b1;
        bus.load_char  = ch;
        bus.load_last  = last;
        n = 0;
        while (!bus.load_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: load_ready stuck at 0, required 1");
        end
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Monitor: every display change (or wrap pulse) must match the next
    // queued expectation, including the edge at which it appeared.
    always @(negedge clock) begin
        logic [15:0] cur;
        exp_t e;
        cur = disp();
        if (mon_en) begin
            if (cur !== prev || bus.wrap_pulse === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got digits %h wrap %b at cycle %0d, required no change",
                             cur, bus.wrap_pulse, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.dig || bus.wrap_pulse !== e.wrap || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL display: got digits %h wrap %b cycle %0d, required digits %h wrap %b cycle %0d",
                                 cur, bus.wrap_pulse, cyc, e.dig, e.wrap, e.cyc);
                    end
                end
            end
        end
        prev = cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq [9];
        int t0;
        int t1;
        int t2;
        seq = '{16'hFFF1, 16'hFF12, 16'hF123, 16'h1234, 16'h234F,
                16'h34FF, 16'h4FFF, 16'hFFFF, 16'hFFF1};

        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_char  = 4'h0;
        bus.load_last  = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.abort      = 1'b0;
        tick();
        tick();
        check("reset_digits", disp(), 16'hFFFF);
        check("reset_busy", bus.busy, 0);
        check("reset_wrap", bus.wrap_pulse, 0);
        check("reset_ready", bus.load_ready, 1);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Start with an empty buffer is ignored.
        do_start();
        check("empty_start_busy", bus.busy, 0);
        check("empty_start_ready", bus.load_ready, 1);

        // Scroll pass with message 1,2,3,4.
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b1);
        do_start();
        t0 = cyc;
        check("start_busy", bus.busy, 1);
        check("start_digits", disp(), 16'hFFFF);
        for (int k = 0; k < 9; k++) begin
            push(seq[k], (k == 7), t0 + 4 * (k + 1));
        end

        // Pause for 10 cycles one cycle after a step: the step resumes
        // after the two remaining ticks plus the resume cycle.
        wait_until(t0 + 37);
        bus.pause = 1'b1;
        push(16'hFF12, 1'b0, t0 + 50);
        push(16'hF123, 1'b0, t0 + 54);
        wait_until(t0 + 47);
        bus.pause = 1'b0;

        // Abort coincident with a step: abort wins, display blanks.
        wait_until(t0 + 57);
        bus.abort = 1'b1;
        push(16'hFFFF, 1'b0, t0 + 58);
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.load_ready, 1);

        // Replay after abort; loads during scroll are refused.
        tick();
        do_start();
        t1 = cyc;
        check("replay_busy", bus.busy, 1);
        push(16'hFFF1, 1'b0, t1 + 4);
        push(16'hFF12, 1'b0, t1 + 8);
        push(16'hF123, 1'b0, t1 + 12);
        push(16'h1234, 1'b0, t1 + 16);
        push(16'hFFFF, 1'b0, t1 + 18);
        wait_until(t1 + 9);
        bus.load_valid = 1'b1;
        bus.load_char  = 4'h7;
        bus.load_last  = 1'b1;
        check("scroll_ready_low", bus.load_ready, 0);
        wait_until(t1 + 13);
        check("hold_ready_low", bus.load_ready, 0);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        wait_until(t1 + 17);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort2_busy", bus.busy, 0);

        // Implicit last: four characters fill the buffer, the fifth waits.
        tick();
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b0;
        bus.load_char  = 4'h9;
        check("implicit_ready_first", bus.load_ready, 1);
        tick();
        bus.load_char = 4'h8;
        tick();
        bus.load_char = 4'h7;
        tick();
        bus.load_char = 4'h6;
        tick();
        bus.load_char = 4'h5;
        bus.load_last = 1'b1;
        check("implicit_ready_drop", bus.load_ready, 0);
        tick();
        check("implicit_ready_back", bus.load_ready, 1);
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("single_ready", bus.load_ready, 1);

        // One-character message: pass length 5 steps.
        do_start();
        t2 = cyc;
        check("single_busy", bus.busy, 1);
        push(16'hFFF5, 1'b0, t2 + 4);
        push(16'hFF5F, 1'b0, t2 + 8);
        push(16'hF5FF, 1'b0, t2 + 12);
        push(16'h5FFF, 1'b0, t2 + 16);
        push(16'hFFFF, 1'b1, t2 + 20);
        push(16'hFFF5, 1'b0, t2 + 24);

        // Reset mid-scroll.
        wait_until(t2 + 24);
        reset = 1'b1;
        push(16'hFFFF, 1'b0, t2 + 25);
        tick();
        reset = 1'b0;
        check("rst_scroll_busy", bus.busy, 0);
        check("rst_scroll_wrap", bus.wrap_pulse, 0);
        check("rst_scroll_ready", bus.load_ready, 1);
        do_start();
        tick();
        check("rst_scroll_start_ignored", bus.busy, 0);

        // Reset mid-load.
        bus.load_valid = 1'b1;
        bus.load_char  = 4'h3;
        tick();
        bus.load_char = 4'h2;
        tick();
        bus.load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_load_ready", bus.load_ready, 1);
        check("rst_load_busy", bus.busy, 0);
        do_start();
        tick();
        check("rst_load_start_ignored", bus.busy, 0);

        repeat (20) tick();
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
